// File: rtl/i2s_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_transmitter
//
// Stereo I2S serial transmitter for the output end of the equalizer chain.
// Accepts one signed left/right sample pair at a time through a valid/ready
// handshake into a one-pair holding buffer. Generates the I2S bit clock and
// word select from the system clock. Sends each channel MSB-first in an
// SLOT_W-bit slot, giving 2*SLOT_W bit clocks per frame. Sample bits beyond
// DATA_W are padded with zeros.
//
// Parameters:
//   CLK_DIV  system clocks per half bit-clock period (>= 2)
//   DATA_W   sample width (<= SLOT_W)
//   SLOT_W   bit clocks per channel slot
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   enable        run control; low freezes divider, bit counter and pins
//   sample_valid  a left/right pair is offered
//   sample_ready  holding buffer is empty
//   left_in       left sample (two's complement)
//   right_in      right sample (two's complement)
//   i2s_bclk      bit clock
//   i2s_lrclk     word select (0 = left, 1 = right)
//   i2s_sdata     serial data, changes on bclk falling edges
//   frame_start   one-clk pulse when a new frame is loaded
//   underrun      one-clk pulse when a frame is loaded with an empty buffer
//
// Build option:
//   I2S_TX_MUTE_ON_UNDERRUN_EN  defined   : an underrun frame sends zeros
//                               undefined : an underrun frame repeats the
//                                           last loaded pair (zero after reset)
// -----------------------------------------------------------------------------
module i2s_transmitter #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic signed [DATA_W-1:0] left_in,
  input  logic signed [DATA_W-1:0] right_in,
  output logic                     i2s_bclk,
  output logic                     i2s_lrclk,
  output logic                     i2s_sdata,
  output logic                     frame_start,
  output logic                     underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0] LR_LAST  = BIT_W'(FRAME_W - 2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]  div_cnt_reg,     div_cnt_next;
  logic              bclk_reg,        bclk_next;
  logic [BIT_W-1:0]  bit_cnt_reg,     bit_cnt_next;
  logic              lrclk_reg,       lrclk_next;
  logic              sdata_reg,       sdata_next;
  logic              frame_start_reg, frame_start_next;
  logic              underrun_reg,    underrun_next;
  logic              full_reg,        full_next;
  logic [DATA_W-1:0] hold_left_reg,   hold_left_next;
  logic [DATA_W-1:0] hold_right_reg,  hold_right_next;
  logic [DATA_W-1:0] shift_left_reg,  shift_left_next;
  logic [DATA_W-1:0] shift_right_reg, shift_right_next;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic              accept;
  logic              tick;
  logic              fall;
  logic              bit_wrap;
  logic [BIT_W-1:0]  bit_cnt_inc;
  logic              load;
  logic [DATA_W-1:0] fallback_left;
  logic [DATA_W-1:0] fallback_right;
  logic [DATA_W-1:0] load_left;
  logic [DATA_W-1:0] load_right;
  logic [DATA_W-1:0] cur_left;
  logic [DATA_W-1:0] cur_right;
  logic              is_right;
  logic [BIT_W-1:0]  slot_pos;
  logic [DATA_W-1:0] chan_word;
  logic [SLOT_W-1:0] slot_rev;
  logic              slot_bit;

  assign accept      = sample_valid && !full_reg;
  assign tick        = enable && (div_cnt_reg == DIV_LAST);
  // bclk is high just before the toggle, so this toggle is a falling edge
  assign fall        = tick && bclk_reg;
  assign bit_wrap    = (bit_cnt_reg == BIT_LAST);
  assign bit_cnt_inc = bit_wrap ? '0 : bit_cnt_reg + BIT_W'(1);
  assign load        = fall && bit_wrap;

`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
  assign fallback_left  = '0;
  assign fallback_right = '0;
`else
  // Repeat: the shift pair still holds the last loaded pair (zero after reset)
  assign fallback_left  = shift_left_reg;
  assign fallback_right = shift_right_reg;
`endif

  // The load decision uses the buffer state before this clock; a pair
  // accepted in the same clock is stored and waits for the next frame.
  assign load_left  = full_reg ? hold_left_reg  : fallback_left;
  assign load_right = full_reg ? hold_right_reg : fallback_right;

  // Bit 0 of a new frame goes out in the same clock as the load, so the
  // serializer must see the pair being loaded rather than the old one.
  assign cur_left  = load ? load_left  : shift_left_reg;
  assign cur_right = load ? load_right : shift_right_reg;

  assign is_right  = (bit_cnt_inc >= SLOT_LEN);
  assign slot_pos  = is_right ? (bit_cnt_inc - SLOT_LEN) : bit_cnt_inc;
  assign chan_word = is_right ? cur_right : cur_left;

  // Slot laid out by transmit position: slot_rev[p] is the bit sent at slot
  // position p (sample MSB first, zero padding after the LSB).
  genvar gi;
  generate
    for (gi = 0; gi < SLOT_W; gi++) begin : g_slot
      if (gi < DATA_W) begin : g_data
        assign slot_rev[gi] = chan_word[DATA_W-1-gi];
      end else begin : g_pad
        assign slot_rev[gi] = 1'b0;
      end
    end
  endgenerate

  assign slot_bit = |(slot_rev & (SLOT_W'(1) << slot_pos));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    div_cnt_next     = div_cnt_reg;
    bclk_next        = bclk_reg;
    bit_cnt_next     = bit_cnt_reg;
    lrclk_next       = lrclk_reg;
    sdata_next       = sdata_reg;
    frame_start_next = 1'b0;
    underrun_next    = 1'b0;
    full_next        = full_reg;
    hold_left_next   = hold_left_reg;
    hold_right_next  = hold_right_reg;
    shift_left_next  = shift_left_reg;
    shift_right_next = shift_right_reg;

    // Divider and bit clock
    if (enable) begin
      div_cnt_next = tick ? '0 : div_cnt_reg + DIV_W'(1);
    end
    if (tick) begin
      bclk_next = ~bclk_reg;
    end

    // Serializer outputs advance on bclk falling edges only.
    // Word select leads the slot by one bit clock.
    if (fall) begin
      bit_cnt_next = bit_cnt_inc;
      lrclk_next   = (bit_cnt_inc >= LR_FIRST) && (bit_cnt_inc <= LR_LAST);
      sdata_next   = slot_bit;
    end

    // Frame load
    if (load) begin
      shift_left_next  = load_left;
      shift_right_next = load_right;
      frame_start_next = 1'b1;
      underrun_next    = !full_reg;
      if (full_reg) begin
        full_next = 1'b0;
      end
    end

    // Handshake; only possible while empty, so it never collides with the
    // buffered load clearing full above.
    if (accept) begin
      hold_left_next  = left_in;
      hold_right_next = right_in;
      full_next       = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg     <= '0;
      bclk_reg        <= 1'b0;
      bit_cnt_reg     <= BIT_LAST;
      lrclk_reg       <= 1'b0;
      sdata_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
      full_reg        <= 1'b0;
      hold_left_reg   <= '0;
      hold_right_reg  <= '0;
      shift_left_reg  <= '0;
      shift_right_reg <= '0;
    end else begin
      div_cnt_reg     <= div_cnt_next;
      bclk_reg        <= bclk_next;
      bit_cnt_reg     <= bit_cnt_next;
      lrclk_reg       <= lrclk_next;
      sdata_reg       <= sdata_next;
      frame_start_reg <= frame_start_next;
      underrun_reg    <= underrun_next;
      full_reg        <= full_next;
      hold_left_reg   <= hold_left_next;
      hold_right_reg  <= hold_right_next;
      shift_left_reg  <= shift_left_next;
      shift_right_reg <= shift_right_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign sample_ready = !full_reg;
  assign i2s_bclk     = bclk_reg;
  assign i2s_lrclk    = lrclk_reg;
  assign i2s_sdata    = sdata_reg;
  assign frame_start  = frame_start_reg;
  assign underrun     = underrun_reg;

endmodule

// File: tb/tb_i2s_transmitter.sv
// -----------------------------------------------------------------------------
// tb_i2s_transmitter
//
// Self-checking bench for i2s_transmitter (CLK_DIV=2, DATA_W=24, SLOT_W=32).
// A table of sample pairs with their expected 32-bit slot images is pushed
// through the handshake. Every accepted pair is queued at the moment of the
// handshake, and each frame_start pops the queue (or expects an underrun and
// the fallback pair). The I2S stream is decoded on bclk rising edges into
// slot words and a word-select pattern, then compared per frame. Hand-written
// sequences cover underrun, accept-during-load, enable freeze and mid-frame
// reset.
// -----------------------------------------------------------------------------
module tb_i2s_transmitter;

  localparam int CLK_DIV    = 2;
  localparam int DATA_W     = 24;
  localparam int SLOT_W     = 32;
  localparam int FRAME_CLKS = 2 * SLOT_W * 2 * CLK_DIV;
  // word select is high for frame bits 31..62
  localparam logic [63:0] LR_MASK = 64'h7FFF_FFFF_8000_0000;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     enable = 1'b1;
  logic                     sample_valid = 1'b0;
  logic                     sample_ready;
  logic signed [DATA_W-1:0] left_in = '0;
  logic signed [DATA_W-1:0] right_in = '0;
  logic                     i2s_bclk;
  logic                     i2s_lrclk;
  logic                     i2s_sdata;
  logic                     frame_start;
  logic                     underrun;

  i2s_transmitter #(
    .CLK_DIV(CLK_DIV),
    .DATA_W (DATA_W),
    .SLOT_W (SLOT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .left_in     (left_in),
    .right_in    (right_in),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
  } pair_t;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  vec_t tab[8];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard and stream decoder
  // ---------------------------------------------------------------------------
  pair_t       sb[$];
  pair_t       cur_exp = '0;
  pair_t       pend = '0;
  logic        pend_v = 1'b0;
  pair_t       fr_exp = '0;
  pair_t       last_pair = '0;
  logic        collecting = 1'b0;
  int          idx = 0;
  logic [31:0] got_l = '0;
  logic [31:0] got_r = '0;
  logic [63:0] got_lr = '0;
  logic        prev_bclk = 1'b0;
  int          per_cnt = 0;
  logic        have_prev = 1'b0;
  logic        per_check = 1'b0;
  logic        bp_check = 1'b0;
  logic        bp_armed = 1'b0;
  int          ready_cnt = 0;
  int          frames_done = 0;
  logic        exp_ur;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      pend_v     = 1'b0;
      last_pair  = '0;
      collecting = 1'b0;
      idx        = 0;
      prev_bclk  = 1'b0;
      have_prev  = 1'b0;
      bp_armed   = 1'b0;
      ready_cnt  = 0;
    end else begin
      per_cnt++;
      // decode one bit per bclk rising edge
      if (i2s_bclk && !prev_bclk && collecting) begin
        if (idx < SLOT_W) got_l = {got_l[30:0], i2s_sdata};
        else              got_r = {got_r[30:0], i2s_sdata};
        got_lr[idx] = i2s_lrclk;
        idx++;
        if (idx == 2 * SLOT_W) begin
          check("frame_left",  got_l,  fr_exp.l);
          check("frame_right", got_r,  fr_exp.r);
          check("frame_lrclk", got_lr, LR_MASK);
          $display("frame %0d: left=%h right=%h lrclk=%h", frames_done, got_l, got_r, got_lr);
          frames_done++;
          collecting = 1'b0;
        end
      end
      prev_bclk = i2s_bclk;

      if (!per_check) have_prev = 1'b0;
      if (!bp_check)  bp_armed  = 1'b0;

      if (frame_start) begin
        check("frame_complete", collecting, 0);
        exp_ur = (sb.size() == 0);
        check("underrun_flag", underrun, exp_ur);
        if (!exp_ur) begin
          fr_exp = sb.pop_front();
        end else begin
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
          fr_exp = '0;
`else
          fr_exp = last_pair;
`endif
        end
        last_pair  = fr_exp;
        collecting = 1'b1;
        idx        = 0;
        got_l      = '0;
        got_r      = '0;
        got_lr     = '0;
        if (have_prev) check("frame_period", per_cnt, FRAME_CLKS);
        have_prev = per_check;
        per_cnt   = 0;
        if (bp_armed) check("ready_per_frame", ready_cnt, 1);
        bp_armed  = bp_check;
        ready_cnt = 0;
      end
      if (sample_ready) ready_cnt++;

      // the handshake seen at the previous negedge completed at the posedge
      // just passed, after any load in that same posedge
      if (pend_v) sb.push_back(pend);
      pend_v = sample_valid && sample_ready;
      pend   = cur_exp;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_pair(input logic [23:0] l, input logic [23:0] r, input pair_t e);
    logic ok;
    @(posedge clk);
    #1;
    sample_valid = 1'b1;
    left_in      = l;
    right_in     = r;
    cur_exp      = e;
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      @(negedge clk);
      if (sample_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("ready_wait", ok, 1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_frame_start();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      @(negedge clk);
      if (frame_start) begin
        found = 1'b1;
        break;
      end
    end
    check("frame_wait", found, 1);
  endtask

  // called right after rst is released between clock edges
  task automatic check_first_load();
    logic found;
    int   cnt;
    found = 1'b0;
    cnt   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (frame_start) begin
        found = 1'b1;
        break;
      end
    end
    check("first_load_found", found, 1);
    check("first_load_clk", cnt, 2 * CLK_DIV);
    check("first_load_underrun", underrun, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bclk"},        i2s_bclk,     0);
    check({tag, "_lrclk"},       i2s_lrclk,    0);
    check({tag, "_sdata"},       i2s_sdata,    0);
    check({tag, "_frame_start"}, frame_start,  0);
    check({tag, "_underrun"},    underrun,     0);
    check({tag, "_ready"},       sample_ready, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [2:0] ref_pins;
  int         chg;
  logic       ok;

  initial begin
    tab[0] = '{24'hA5A5A5, 24'h5A5A5A, 32'hA5A5A500, 32'h5A5A5A00};
    tab[1] = '{24'h7FFFFF, 24'h800000, 32'h7FFFFF00, 32'h80000000};
    tab[2] = '{24'h000001, 24'hF00001, 32'h00000100, 32'hF0000100};
    tab[3] = '{24'h000002, 24'hF00002, 32'h00000200, 32'hF0000200};
    tab[4] = '{24'h000003, 24'hF00003, 32'h00000300, 32'hF0000300};
    tab[5] = '{24'h000004, 24'hF00004, 32'h00000400, 32'hF0000400};
    tab[6] = '{24'h123456, 24'h654321, 32'h12345600, 32'h65432100};
    tab[7] = '{24'hABCDEF, 24'h13579B, 32'hABCDEF00, 32'h13579B00};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    check_first_load();

    // table: continuous offering, frame period and backpressure checked
    per_check = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_pair(tab[i].l, tab[i].r, {tab[i].exp_l, tab[i].exp_r});
      if (i == 0) bp_check = 1'b1;
    end
    bp_check = 1'b0;

    // underrun: 123456/654321 loads next, the frame after it underruns
    wait_frame_start();
    check("pair_loaded_no_underrun", underrun, 0);
    wait_frame_start();
    check("underrun_pulse", underrun, 1);
    per_check = 1'b0;

    // accept in the exact clock of the next load, with the buffer empty
    repeat (FRAME_CLKS - 1) @(posedge clk);
    #1;
    sample_valid = 1'b1;
    left_in      = 24'hC0FFEE;
    right_in     = 24'h0BADF0;
    cur_exp      = {32'hC0FFEE00, 32'h0BADF000};
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    @(negedge clk);
    check("sim_frame_start", frame_start, 1);
    check("sim_underrun", underrun, 1);
    check("sim_stored", sample_ready, 0);

    // next frame carries the new pair; freeze it mid-left-slot
    wait_frame_start();
    check("sim_next_no_underrun", underrun, 0);
    repeat (60) @(posedge clk);
    #1;
    enable   = 1'b0;
    ref_pins = {i2s_bclk, i2s_lrclk, i2s_sdata};
    chg      = 0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      if ({i2s_bclk, i2s_lrclk, i2s_sdata} !== ref_pins) chg++;
    end
    #1;
    enable = 1'b1;
    check("freeze_pin_changes", chg, 0);

    // reset in the middle of the right slot with a pair buffered
    wait_frame_start();
    send_pair(tab[7].l, tab[7].r, {tab[7].exp_l, tab[7].exp_r});
    check("buffer_full_before_reset", sample_ready, 0);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk);
      #1;
      if (collecting && idx >= SLOT_W + 10) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_right_bit10", ok, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    check_first_load();
    wait_frame_start();

    check("scoreboard_drained", sb.size(), 0);
    check("frames_seen", (frames_done >= 12), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop if the sequence itself ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
